sfx_voice_bank: RTL

Parametrised multi-channel sound-effect generator replacing hard-wired discrete analog SFX paths (walk/jump/crash style) with digital voices. Each channel takes a level trigger from the SFX latch, runs an attack/hold/decay envelope and gates either a programmable square tone or shared LFSR noise. Channel outputs are summed, saturated and muted into one unsigned DAC sample, which is mixed alongside the sound-CPU DAC output. The noise generator is a generalised form of the vertical-timing-clocked LFSR/counter already used in the sound section.

---
 rtl/sfx_voice_bank.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sfx_voice_bank.sv
// Multi-channel SFX voice bank: per-channel attack/hold/decay envelope gating a
// square tone or shared LFSR noise, summed into one saturated, mutable DAC sample.
module sfx_voice_bank #(
    parameter int NUM_CH      = 3,
    parameter int LFSR_W      = 24,
    parameter int TAP_A       = 23,
    parameter int TAP_B       = 10,
    parameter int NOISE_DIV_W = 3,
    parameter int ENV_W       = 8,
    parameter int DIV_W       = 12,
    parameter int OUT_W       = 8
) (
    input  logic                    masterclk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH-1:0]       ch_noise,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    input  logic [NUM_CH*4-1:0]     ch_attack,
    input  logic [NUM_CH*4-1:0]     ch_decay,
    input  logic                    mute,
    output logic [OUT_W-1:0]        mix_out,
    output logic [NUM_CH-1:0]       ch_active,
    output logic                    noise_out
);

    typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_HOLD, S_DECAY} env_state_t;

    localparam int SUM_W = ENV_W + $clog2(NUM_CH + 1);
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [ENV_W:0]   ENV_FULL = {1'b0, {ENV_W{1'b1}}};
    localparam logic [CMP_W-1:0] OUT_FULL = {CMP_W{1'b1}} >> (CMP_W - OUT_W);

    logic                   tick_d, tick_rise, fb, fb_d;
    logic [LFSR_W-1:0]      lfsr;
    logic [NOISE_DIV_W-1:0] noise_div;
    logic [NUM_CH-1:0]      trig_d, rise_pend, fall_pend, rise_any, fall_any, rise_ev, fall_ev, sq;
    env_state_t             state [NUM_CH];
    env_state_t             state_nxt [NUM_CH];
    logic [ENV_W-1:0]       env [NUM_CH];
    logic [ENV_W-1:0]       env_nxt [NUM_CH];
    logic [DIV_W-1:0]       cnt [NUM_CH];
    logic [CMP_W-1:0]       mix_sum;

    function automatic logic [ENV_W-1:0] env_up(input logic [ENV_W-1:0] e, input logic [3:0] s);
        logic [ENV_W:0] t;
        t = {1'b0, e} + (ENV_W+1)'((s == 4'd0) ? 4'd1 : s);
        return (t > ENV_FULL) ? {ENV_W{1'b1}} : t[ENV_W-1:0];
    endfunction

    function automatic logic [ENV_W-1:0] env_down(input logic [ENV_W-1:0] e, input logic [3:0] s);
        logic [ENV_W-1:0] d;
        d = ENV_W'((s == 4'd0) ? 4'd1 : s);
        return (e <= d) ? '0 : e - d;
    endfunction

    assign tick_rise = tick & ~tick_d;
    assign fb        = lfsr[TAP_A] ^ lfsr[TAP_B];
    assign noise_out = noise_div[NOISE_DIV_W-1];
    assign rise_any  = rise_pend | (trig & ~trig_d);
    assign fall_any  = fall_pend | (~trig & trig_d);
    // With both edges pending since the last tick, the present trig level wins.
    assign rise_ev   = rise_any & (~fall_any | trig);
    assign fall_ev   = fall_any & (~rise_any | ~trig);

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            env_nxt[i]   = env[i];
            if (tick_rise) begin
                case (state[i])
                    S_IDLE:   if (rise_ev[i]) state_nxt[i] = S_ATTACK;
                    S_ATTACK: begin
                        if (fall_ev[i]) begin
                            state_nxt[i] = S_DECAY;
                        end else begin
                            env_nxt[i] = env_up(env[i], ch_attack[i*4 +: 4]);
                            if (env_nxt[i] == {ENV_W{1'b1}}) state_nxt[i] = S_HOLD;
                        end
                    end
                    S_HOLD:   if (!trig[i]) state_nxt[i] = S_DECAY;
                    S_DECAY: begin
                        if (rise_ev[i]) begin
                            state_nxt[i] = S_ATTACK;
                        end else begin
                            env_nxt[i] = env_down(env[i], ch_decay[i*4 +: 4]);
                            if (env_nxt[i] == '0) state_nxt[i] = S_IDLE;
                        end
                    end
                    default:  state_nxt[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_noise[i] ? noise_out : sq[i]) mix_sum = mix_sum + CMP_W'(env[i]);
        end
    end

    // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            tick_d    <= 1'b0;
            fb_d      <= 1'b0;
            lfsr      <= '0;
            noise_div <= '0;
            trig_d    <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
            sq        <= '0;
            ch_active <= '0;
            mix_out   <= '0;
            // NOTE: the per-channel arrays are plain flops, not RAM, so they are cleared here too.
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= S_IDLE;
                env[i]   <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            tick_d <= tick;
            fb_d   <= fb;
            trig_d <= trig;
            if (tick_rise) begin
                lfsr      <= {lfsr[LFSR_W-2:0], ~fb};
                rise_pend <= '0;
                fall_pend <= '0;
                if (!fb_d && fb) noise_div <= noise_div + NOISE_DIV_W'(1);
            end else begin
                rise_pend <= rise_any;
                fall_pend <= fall_any;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]     <= state_nxt[i];
                env[i]       <= env_nxt[i];
                ch_active[i] <= (state_nxt[i] != S_IDLE);
                // Tone divider free-runs while the voice sounds; a divider of 0 gives DC.
                if (state[i] == S_IDLE) begin
                    cnt[i] <= '0;
                    sq[i]  <= 1'b0;
                end else if (ch_div[i*DIV_W +: DIV_W] == '0) begin
                    sq[i] <= 1'b1;
                end else if (cnt[i] == ch_div[i*DIV_W +: DIV_W] - DIV_W'(1)) begin
                    cnt[i] <= '0;
                    sq[i]  <= ~sq[i];
                end else begin
                    cnt[i] <= cnt[i] + DIV_W'(1);
                end
            end
            mix_out <= mute ? '0 : (mix_sum > OUT_FULL) ? '1 : mix_sum[OUT_W-1:0];
        end
    end

endmodule
